// File: rtl/case_scan_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | case_scan_pkg : shared types, widths and helpers for case_item_scanner      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package case_scan_pkg;

  localparam int c_SEL_W   = 4;
  localparam int c_N_ITEMS = 8;
  localparam int c_IDX_W   = $clog2(c_N_ITEMS);
  localparam int c_WW      = $clog2(c_SEL_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CTX   = 2'd1,
    ST_MATCH = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic               en;
    logic [c_SEL_W-1:0] val;
    logic [c_WW-1:0]    w;
    logic               sgn;
`ifdef CASE_SCAN_WILDCARD_EN
    logic [c_SEL_W-1:0] mask;
`endif
  } item_entry_t;

  typedef struct packed {
    logic               hit;
    logic [c_IDX_W-1:0] idx;
    logic               dflt;
  } scan_result_t;

  // A zero width means one bit; anything wider than the datapath saturates.
  function automatic logic [c_WW-1:0] norm_w(input logic [c_WW-1:0] w);
    logic [c_WW-1:0] r;
    if (w == '0)                     r = c_WW'(1);
    else if (w > c_WW'(c_SEL_W))     r = c_WW'(c_SEL_W);
    else                             r = w;
    return r;
  endfunction

  function automatic logic [c_SEL_W-1:0] width_mask(input logic [c_WW-1:0] w);
    logic [c_SEL_W-1:0] m;
    for (int i = 0; i < c_SEL_W; i++) m[i] = (i < int'(w));
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/case_item_scanner_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | case_item_scanner_if : table-write, request and result handshake bundle    |
// | Optional CASE_SCAN_WILDCARD_EN adds item_mask.  Rev 1.0                     |
// +-----------------------------------------------------------------------------+
interface case_item_scanner_if;
  import case_scan_pkg::*;

  logic               item_we;
  logic [c_IDX_W-1:0] item_idx;
  logic               item_en;
  logic [c_SEL_W-1:0] item_val;
  logic [c_WW-1:0]    item_w;
  logic               item_signed;
`ifdef CASE_SCAN_WILDCARD_EN
  logic [c_SEL_W-1:0] item_mask;
`endif
  logic               in_valid;
  logic               in_ready;
  logic [c_SEL_W-1:0] sel_val;
  logic [c_WW-1:0]    sel_w;
  logic               sel_signed;
  logic               out_valid;
  logic               out_ready;
  logic               out_hit;
  logic [c_IDX_W-1:0] out_idx;
  logic               out_default;

  modport master (
    output item_we, item_idx, item_en, item_val, item_w, item_signed,
`ifdef CASE_SCAN_WILDCARD_EN
    output item_mask,
`endif
    output in_valid, sel_val, sel_w, sel_signed, out_ready,
    input  in_ready, out_valid, out_hit, out_idx, out_default
  );

  modport slave (
    input  item_we, item_idx, item_en, item_val, item_w, item_signed,
`ifdef CASE_SCAN_WILDCARD_EN
    input  item_mask,
`endif
    input  in_valid, sel_val, sel_w, sel_signed, out_ready,
    output in_ready, out_valid, out_hit, out_idx, out_default
  );
endinterface
`default_nettype wire

// File: rtl/case_operand_ext.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | case_operand_ext : truncate an operand to its own width, then sign- or     |
// | zero-extend it to the full datapath as the case context dictates. Rev 1.0  |
// +-----------------------------------------------------------------------------+
module case_operand_ext
  import case_scan_pkg::*;
(
  input  wire logic [c_SEL_W-1:0] val,
  input  wire logic [c_WW-1:0]    w,
  input  wire logic               is_signed,
  input  wire logic               ctx_s,
  output logic      [c_SEL_W-1:0] ext
);
  logic [c_SEL_W-1:0] w_mask;
  logic               w_msb;

  always_comb begin
    w_mask = width_mask(norm_w(w));
    // The top set bit of the mask marks the operand's own sign bit.
    w_msb  = |(val & w_mask & ~(w_mask >> 1));
    ext    = (val & w_mask) | ((is_signed && ctx_s && w_msb) ? ~w_mask : '0);
  end
endmodule
`default_nettype wire

// File: rtl/case_item_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | case_item_scanner : two-pass case-item scan (context, then first match)    |
// | Optional CASE_SCAN_WILDCARD_EN enables casez-style item masks.  Rev 1.0    |
// +-----------------------------------------------------------------------------+
module case_item_scanner
  import case_scan_pkg::*;
#(
  parameter int SEL_W   = c_SEL_W,
  parameter int N_ITEMS = c_N_ITEMS,
  parameter int IDX_W   = c_IDX_W,
  parameter int WW      = c_WW
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  case_item_scanner_if.slave bus
);
  localparam logic [1:0] c_S_IDLE  = ST_IDLE;
  localparam logic [1:0] c_S_CTX   = ST_CTX;
  localparam logic [1:0] c_S_MATCH = ST_MATCH;
  localparam logic [1:0] c_S_DONE  = ST_DONE;

  logic [1:0]       r_state;
  item_entry_t      r_tbl [N_ITEMS];
  logic [SEL_W-1:0] r_sel_val;
  logic [WW-1:0]    r_sel_w;
  logic             r_sel_s;
  logic [WW-1:0]    r_ctx_w;
  logic             r_ctx_s;
  logic [IDX_W-1:0] r_idx;
  scan_result_t     r_res;
  logic             r_out_valid;

  item_entry_t      w_cur;
  logic [WW-1:0]    w_item_w;
  logic [SEL_W-1:0] w_sel_ext;
  logic [SEL_W-1:0] w_item_ext;
  logic [SEL_W-1:0] w_dc;
  logic             w_eq;
  logic             w_last;

  assign w_cur    = r_tbl[r_idx];
  assign w_item_w = norm_w(w_cur.w);
  assign w_last   = (r_idx == IDX_W'(N_ITEMS - 1));

  case_operand_ext u_sel_ext (
    .val(r_sel_val), .w(r_sel_w), .is_signed(r_sel_s), .ctx_s(r_ctx_s), .ext(w_sel_ext)
  );

  case_operand_ext u_item_ext (
    .val(w_cur.val), .w(w_cur.w), .is_signed(w_cur.sgn), .ctx_s(r_ctx_s), .ext(w_item_ext)
  );

`ifdef CASE_SCAN_WILDCARD_EN
  // Only bits inside the item's own width may be don't-care.
  assign w_dc = w_cur.mask & width_mask(w_item_w);
`else
  assign w_dc = '0;
`endif

  assign w_eq = ~|((w_sel_ext ^ w_item_ext) & width_mask(r_ctx_w) & ~w_dc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_S_IDLE;
      for (int i = 0; i < N_ITEMS; i++) r_tbl[i] <= '0;
      r_sel_val   <= '0;
      r_sel_w     <= '0;
      r_sel_s     <= 1'b0;
      r_ctx_w     <= '0;
      r_ctx_s     <= 1'b0;
      r_idx       <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (bus.item_we) begin
            r_tbl[bus.item_idx].en  <= bus.item_en;
            r_tbl[bus.item_idx].val <= bus.item_val;
            r_tbl[bus.item_idx].w   <= bus.item_w;
            r_tbl[bus.item_idx].sgn <= bus.item_signed;
`ifdef CASE_SCAN_WILDCARD_EN
            r_tbl[bus.item_idx].mask <= bus.item_mask;
`endif
          end
          if (bus.in_valid) begin
            r_sel_val <= bus.sel_val;
            r_sel_w   <= norm_w(bus.sel_w);
            r_sel_s   <= bus.sel_signed;
            r_ctx_w   <= norm_w(bus.sel_w);
            r_ctx_s   <= bus.sel_signed;
            r_idx     <= '0;
            r_state   <= c_S_CTX;
          end
        end
        c_S_CTX: begin
          if (w_cur.en) begin
            if (w_item_w > r_ctx_w) r_ctx_w <= w_item_w;
            if (!w_cur.sgn)         r_ctx_s <= 1'b0;
          end
          r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
          if (w_last) r_state <= c_S_MATCH;
        end
        c_S_MATCH: begin
          if (w_cur.en && w_eq) begin
            r_res       <= '{hit: 1'b1, idx: r_idx, dflt: 1'b0};
            r_out_valid <= 1'b1;
            r_state     <= c_S_DONE;
          end else if (w_last) begin
            r_res       <= '{hit: 1'b0, idx: '0, dflt: 1'b1};
            r_out_valid <= 1'b1;
            r_state     <= c_S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        c_S_DONE: begin
          if (bus.out_ready) begin
            r_res       <= '0;
            r_out_valid <= 1'b0;
            r_state     <= c_S_IDLE;
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == c_S_IDLE);
  assign bus.out_valid   = r_out_valid;
  assign bus.out_hit     = r_res.hit;
  assign bus.out_idx     = r_res.idx;
  assign bus.out_default = r_res.dflt;

endmodule
`default_nettype wire
